// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU in EX.
// Returns {remainder, quotient} and stalls the pipeline while a divide is in progress.
module div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               div_start_i,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               annul_i,
    output logic               stallreq_o,
    output logic               ready_o,
    output logic [2*WIDTH-1:0] result_o
);

    typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dsr;
    logic [WIDTH-1:0] rem;
    logic             sgn;
    logic             s1;
    logic             s2;

    logic [WIDTH:0]   shifted;
    logic             qbit;
    logic [WIDTH-1:0] rem_nxt;
    logic [WIDTH-1:0] quo_nxt;

    function automatic logic [WIDTH-1:0] neg_if(input logic en, input logic [WIDTH-1:0] x);
        return en ? (~x + 1'b1) : x;
    endfunction

    function automatic logic [WIDTH-1:0] abs_val(input logic sgn_en, input logic [WIDTH-1:0] x);
        return neg_if(sgn_en & x[WIDTH-1], x);
    endfunction

    // One restoring step: the subtraction result fits in WIDTH bits whenever it is kept.
    always_comb begin
        shifted = {rem, dvd[WIDTH-1]};
        qbit    = (shifted >= {1'b0, dsr});
        rem_nxt = qbit ? (shifted[WIDTH-1:0] - dsr) : shifted[WIDTH-1:0];
        quo_nxt = {dvd[WIDTH-2:0], qbit};
    end

    always_comb begin
        stallreq_o = 1'b0;
        case (state)
            FREE:       stallreq_o = div_start_i & ~annul_i;
            BYZERO, ON: stallreq_o = 1'b1;
            default:    stallreq_o = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FREE;
            cnt      <= '0;
            ready_o  <= 1'b0;
            result_o <= '0;
        end else begin
            case (state)
                FREE: begin
                    if (div_start_i && !annul_i) begin
                        if (opdata2_i == '0) begin
                            state <= BYZERO;
                        end else begin
                            dvd   <= abs_val(signed_div_i, opdata1_i);
                            dsr   <= abs_val(signed_div_i, opdata2_i);
                            sgn   <= signed_div_i;
                            s1    <= opdata1_i[WIDTH-1];
                            s2    <= opdata2_i[WIDTH-1];
                            rem   <= '0;
                            cnt   <= '0;
                            state <= ON;
                        end
                    end
                end
                BYZERO: begin
                    if (annul_i) begin
                        state <= FREE;
                    end else begin
                        result_o <= '0;
                        ready_o  <= 1'b1;
                        state    <= END;
                    end
                end
                ON: begin
                    if (annul_i) begin
                        state <= FREE;
                    end else begin
                        dvd <= quo_nxt;
                        rem <= rem_nxt;
                        cnt <= cnt + 1'b1;
                        // Last step: sign fix-up is folded into the result register load.
                        if (cnt == LAST) begin
                            result_o <= {neg_if(sgn & s1, rem_nxt), neg_if(sgn & (s1 ^ s2), quo_nxt)};
                            ready_o  <= 1'b1;
                            state    <= END;
                        end
                    end
                end
                END: begin
                    if (!div_start_i) begin
                        ready_o <= 1'b0;
                        state   <= FREE;
                    end
                end
                default: state <= FREE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: driver pushes expected results, monitor checks each ready_o rise.
module tb_div_unit;

    localparam int WIDTH = 32;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                div_start = 1'b0;
    logic                signed_div = 1'b0;
    logic [WIDTH-1:0]    op1 = '0;
    logic [WIDTH-1:0]    op2 = '0;
    logic                annul = 1'b0;
    logic                stallreq;
    logic                ready;
    logic [2*WIDTH-1:0]  result;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [63:0] res;
        int          start_cyc;
        int          lat;
    } exp_t;
    exp_t exp_q[$];

    div_unit #(.WIDTH(WIDTH), .CNT_W(6)) dut (
        .clk          (clk),
        .rst          (rst),
        .div_start_i  (div_start),
        .signed_div_i (signed_div),
        .opdata1_i    (op1),
        .opdata2_i    (op2),
        .annul_i      (annul),
        .stallreq_o   (stallreq),
        .ready_o      (ready),
        .result_o     (result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain integer division, truncating toward zero, remainder takes dividend sign.
    function automatic logic [63:0] ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        longint na, nb, q, r;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            na = longint'($signed(a));
            nb = longint'($signed(b));
        end else begin
            na = longint'({32'd0, a});
            nb = longint'({32'd0, b});
        end
        q = na / nb;
        r = na % nb;
        return {r[31:0], q[31:0]};
    endfunction

    // Monitor: compare on each rising edge of ready_o.
    logic rdy_q = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            rdy_q = 1'b0;
        end else begin
            if (ready && !rdy_q) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ready: got result %h with no pending op", result);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("result", result, e.res);
                    chk("latency", 64'(cyc - e.start_cyc), 64'(e.lat));
                end
            end
            rdy_q = ready;
        end
    end

    task automatic run_div(input bit sgn, input logic [31:0] a, input logic [31:0] b, input int hold);
        int  stall_n;
        bit  got;
        int  lat;
        exp_t e;
        lat = (b == 32'd0) ? 2 : WIDTH + 1;
        @(posedge clk); #1;
        div_start  = 1'b1;
        signed_div = sgn;
        op1        = a;
        op2        = b;
        e.res = ref_div(sgn, a, b);
        e.start_cyc = cyc;
        e.lat = lat;
        exp_q.push_back(e);
        stall_n = 0;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (ready) got = 1'b1;
            else if (stallreq) stall_n++;
            if (i == 1) begin
                op1 = $urandom;
                op2 = $urandom;
                signed_div = $urandom_range(0, 1);
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL timeout: ready got 0 expected 1 within 100 cycles");
            return;
        end
        chk("stall_cycles", 64'(stall_n), 64'(lat));
        chk("stall_at_ready", 64'(stallreq), 64'd0);
        repeat (hold) @(posedge clk);
        @(posedge clk); #1;
        div_start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("ready_after_drop", 64'(ready), 64'd0);
        chk("stall_after_drop", 64'(stallreq), 64'd0);
        chk("result_hold", result, e.res);
    endtask

    // Start an unsigned divide and kill it with annul (use_rst=0) or reset (use_rst=1) after n ON cycles.
    task automatic abort_div(input bit use_rst, input int n);
        @(posedge clk); #1;
        div_start  = 1'b1;
        signed_div = 1'b0;
        op1        = $urandom;
        op2        = $urandom_range(1, 1000);
        repeat (n) @(posedge clk);
        #1;
        div_start = 1'b0;
        if (use_rst) rst = 1'b1;
        else annul = 1'b1;
        @(posedge clk); #1;
        rst   = 1'b0;
        annul = 1'b0;
        @(negedge clk);
        chk(use_rst ? "rst_ready" : "annul_ready", 64'(ready), 64'd0);
        chk(use_rst ? "rst_stall" : "annul_stall", 64'(stallreq), 64'd0);
        if (use_rst) chk("rst_result", result, 64'd0);
    endtask

    initial begin
        logic [31:0] a, b;
        bit          s;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ready", 64'(ready), 64'd0);
        chk("reset_result", result, 64'd0);
        chk("reset_stall", 64'(stallreq), 64'd0);
        #1;
        rst = 1'b0;

        run_div(1'b0, 32'd100, 32'd7, 0);
        chk("divu_100_7", result, 64'h00000002_0000000E);
        run_div(1'b1, 32'hFFFFFFF9, 32'h00000002, 1);
        chk("div_m7_2", result, 64'hFFFFFFFF_FFFFFFFD);
        run_div(1'b1, 32'h00000007, 32'hFFFFFFFE, 2);
        chk("div_7_m2", result, 64'h00000001_FFFFFFFD);
        run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 0);
        chk("div_overflow", result, 64'h00000000_80000000);
        run_div(1'b0, 32'hFFFFFFFF, 32'h00000001, 0);
        chk("divu_max_1", result, 64'h00000000_FFFFFFFF);
        run_div(1'b0, 32'd5, 32'd0, 0);
        chk("divu_by_zero", result, 64'd0);

        abort_div(1'b0, 10);
        run_div(1'b0, 32'd9, 32'd3, 0);
        chk("divu_9_3", result, 64'h00000000_00000003);

        abort_div(1'b1, 20);
        run_div(1'b0, 32'd100, 32'd7, 0);
        chk("divu_100_7_after_rst", result, 64'h00000002_0000000E);

        for (int k = 0; k < 40; k++) begin
            s = $urandom_range(0, 1);
            a = $urandom;
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = $urandom_range(1, 15);
                2:       b = 32'hFFFFFFFF;
                3:       b = {1'b1, 31'($urandom)};
                default: b = $urandom;
            endcase
            if (k % 7 == 0) a = 32'h80000000;
            run_div(s, a, b, $urandom_range(0, 2));
        end

        repeat (2) @(posedge clk);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle radix-2 restoring divider. It is the execution-side responder to the DIV/DIVU operations that the decode stage issues on hilo_op.
- Sits in EX. It accepts operands from the decode bus, holds the pipeline through stallreq_o while busy, and returns {remainder, quotient} for the HI/LO write path.
- One operation at a time. No pipelining of divides.

Parameters:
- WIDTH, 32, operand width in bits. Quotient and remainder are WIDTH each.
- CNT_W, 6, iteration counter width. Must satisfy 2**CNT_W > WIDTH.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- div_start_i  in  1  request. Held high by EX until ready_o is seen.
- signed_div_i  in  1  1 = DIV (signed), 0 = DIVU
- opdata1_i  in  WIDTH  dividend (rs)
- opdata2_i  in  WIDTH  divisor (rt)
- annul_i  in  1  cancel the in-flight divide (flush)
- stallreq_o  out  1  stall request to the pipeline controller
- ready_o  out  1  result valid
- result_o  out  2*WIDTH  {remainder (HI), quotient (LO)}

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on rst.
- Reset: state=FREE, counter=0, ready_o=0, result_o=0. Reset overrides every other input, including mid-operation.
- States: FREE, BYZERO, ON, END.
- FREE:
  - If div_start_i & ~annul_i and opdata2_i==0: go to BYZERO.
  - Else if div_start_i & ~annul_i: latch |dividend| and |divisor|, latch signed_div_i and both operand sign bits, clear the partial remainder, counter=0, go to ON.
  - |x| is the two's-complement negate when signed_div_i & x[WIDTH-1], otherwise x. The absolute value of 0x80000000 is 0x80000000, treated as unsigned.
- BYZERO: go to END with result = 0 (quotient 0, remainder 0).
- ON:
  - Each cycle performs one restoring step. Shift {rem, dividend} left by 1, then trial = rem - divisor.
  - If trial ≥ 0 (unsigned, WIDTH+1-bit compare): rem = trial, quotient bit = 1. Otherwise quotient bit = 0.
  - counter increments. After the WIDTH-th step (counter==WIDTH-1 at the edge), go to END.
- END:
  - Apply sign fix-up. Quotient is negated if signed & (s1^s2). Remainder is negated if signed & s1.
  - Drive result_o and ready_o=1.
  - Remain in END while div_start_i=1. Return to FREE, with ready_o=0, on the first cycle div_start_i=0.
  - result_o holds its value after leaving END until the next operation completes.
- annul_i:
  - In ON or BYZERO: go to FREE next edge, no result, ready_o stays 0.
  - In FREE: blocks the start.
  - In END: ignored.
- Latency:
  - The start is sampled in FREE at edge k. ON occupies edges k+1 .. k+WIDTH.
  - ready_o=1 in the cycle after edge k+WIDTH, i.e. WIDTH+1 cycles after the start cycle.
  - Divide-by-zero: ready_o=1 two cycles after the start cycle.
- stallreq_o (combinational):
  - 1 in FREE when div_start_i & ~annul_i.
  - 1 in BYZERO and ON.
  - 0 in END, so the held instruction advances in the cycle ready_o is seen.
- Overflow: signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 (wraps) and remainder 0. No exception.
- Operand inputs are sampled only on the FREE→ON/BYZERO edge. Later changes on those inputs are ignored.

Test Plan:
- DIVU 100 / 7: ready_o rises exactly 33 cycles after start; result_o={0x00000002, 0x0000000E}; stallreq_o=1 for 33 cycles, then 0 while ready_o=1.
- DIV -7 / 2 (0xFFFFFFF9, 0x00000002): quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Also 7 / -2 gives quotient 0xFFFFFFFD, remainder 0x00000001.
- DIV 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0. DIVU 0xFFFFFFFF / 1: quotient 0xFFFFFFFF, remainder 0.
- Divisor 0 (DIVU 5 / 0): ready_o=1 two cycles after start, result_o=0; then drop start and confirm FREE, with stallreq_o=0 and ready_o=0 the next cycle.
- annul_i pulsed at the 10th ON cycle: ready_o never asserts, stallreq_o=0 next cycle. A new DIVU 9 / 3 started the following cycle returns quotient 3, remainder 0 after 33 cycles.
- rst asserted at the 20th ON cycle: next cycle state FREE, ready_o=0, result_o=0. A subsequent DIVU 100 / 7 completes correctly.
